fp_div_seq: RTL

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq_pkg.sv | 32 +++
 rtl/fp_div_special.sv | 43 ++++
 rtl/fp_div_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fp_div_seq_pkg.sv
// Shared parameters, encodings and state type for the sequential single-precision divider.
package fp_div_seq_pkg;

    localparam int WIDTH     = 32;
    localparam int EXP_WIDTH = 8;
    localparam int SIG_WIDTH = 23;
    localparam int BIAS      = 127;

    localparam logic [WIDTH-1:0] QNAN       = 32'h7FC0_0000;
    localparam logic [WIDTH-1:0] POS_INF    = 32'h7F80_0000;
    localparam logic [WIDTH-1:0] NEG_INF    = 32'hFF80_0000;
    localparam logic [WIDTH-1:0] MAX_FINITE = 32'h7F7F_FFFF;

    localparam logic [1:0] RND_RNE = 2'b00;
    localparam logic [1:0] RND_RTZ = 2'b01;
    localparam logic [1:0] RND_POS = 2'b10;
    localparam logic [1:0] RND_NEG = 2'b11;

    // Quotient bits: integer, fraction, guard, round.
    localparam int QBITS  = SIG_WIDTH + 3;
    // Working exponent width leaves room for sign and overflow past the biased range.
    localparam int EXPC_W = EXP_WIDTH + 2;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_t;

endpackage

// File: rtl/fp_div_special.sv
// Combinational detection of NaN/infinity/zero operand combinations and their fixed results.
module fp_div_special
    import fp_div_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             hit,
    output logic [WIDTH-1:0] value
);

    logic sign;
    logic a_exp_max, b_exp_max, a_frac_nz, b_frac_nz;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sign      = a[WIDTH-1] ^ b[WIDTH-1];
    assign a_exp_max = &a[WIDTH-2:SIG_WIDTH];
    assign b_exp_max = &b[WIDTH-2:SIG_WIDTH];
    assign a_frac_nz = |a[SIG_WIDTH-1:0];
    assign b_frac_nz = |b[SIG_WIDTH-1:0];
    assign a_nan     = a_exp_max & a_frac_nz;
    assign b_nan     = b_exp_max & b_frac_nz;
    assign a_inf     = a_exp_max & ~a_frac_nz;
    assign b_inf     = b_exp_max & ~b_frac_nz;
    // Subnormals are flushed: any zero exponent counts as zero.
    assign a_zero    = ~|a[WIDTH-2:SIG_WIDTH];
    assign b_zero    = ~|b[WIDTH-2:SIG_WIDTH];

    always_comb begin
        hit   = 1'b1;
        value = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            value = QNAN;
        end else if (a_inf || b_zero) begin
            value = sign ? NEG_INF : POS_INF;
        end else if (a_zero || b_inf) begin
            value = {sign, {(WIDTH-1){1'b0}}};
        end else begin
            hit   = 1'b0;
            value = '0;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring divide, one quotient bit per cycle.
module fp_div_seq
    import fp_div_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       rnd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic signed [EXPC_W-1:0] BIAS_S    = EXPC_W'(BIAS);
    localparam logic signed [EXPC_W-1:0] EXP_MAX_S = EXPC_W'(EXP_MAX);
    localparam logic [4:0]               LAST_CNT  = 5'(QBITS - 1);

    state_t state, state_next;
    logic [4:0] cnt;
    logic       accept;

    logic                     sp_hit;
    logic [WIDTH-1:0]         sp_val;
    logic [SIG_WIDTH:0]       sig_a, sig_b;
    logic                     a_lt_b;
    logic signed [EXPC_W-1:0] exp_init;

    logic                     sign, special;
    logic [1:0]               mode;
    logic [WIDTH-1:0]         special_val;
    logic signed [EXPC_W-1:0] exp;
    logic [SIG_WIDTH:0]       divisor;
    logic [SIG_WIDTH+1:0]     rem, rem_next;
    logic [SIG_WIDTH+2:0]     diff;
    logic                     q_bit;
    logic [QBITS-1:0]         quo;

    fp_div_special u_special (
        .a     (A),
        .b     (B),
        .hit   (sp_hit),
        .value (sp_val)
    );

    function automatic logic [WIDTH-1:0] round_pack(
        input logic                     s,
        input logic signed [EXPC_W-1:0] e,
        input logic [QBITS-1:0]         q,
        input logic                     sticky,
        input logic [1:0]               m
    );
        logic                     inexact, inc, ovf_inf;
        logic [SIG_WIDTH+1:0]     sig;
        logic signed [EXPC_W-1:0] ef;
        inexact = q[1] | q[0] | sticky;
        unique case (m)
            RND_RNE: begin inc = q[1] & (q[0] | sticky | q[2]); ovf_inf = 1'b1; end
            RND_RTZ: begin inc = 1'b0;                          ovf_inf = 1'b0; end
            RND_POS: begin inc = ~s & inexact;                  ovf_inf = ~s;   end
            RND_NEG: begin inc = s & inexact;                   ovf_inf = s;    end
        endcase
        sig = {1'b0, q[QBITS-1:2]} + {{(SIG_WIDTH+1){1'b0}}, inc};
        ef  = e;
        // Carry out of the significand renormalises to 1.0 at the next exponent.
        if (sig[SIG_WIDTH+1]) begin
            sig = sig >> 1;
            ef  = e + EXPC_W'(1);
        end
        if (ef >= EXP_MAX_S)
            return ovf_inf ? {s, POS_INF[WIDTH-2:0]} : {s, MAX_FINITE[WIDTH-2:0]};
        else if (ef <= 0)
            return {s, {(WIDTH-1){1'b0}}};
        else
            return {s, ef[EXP_WIDTH-1:0], sig[SIG_WIDTH-1:0]};
    endfunction

    assign accept = (state == S_IDLE) && start;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    // Operand prescale so the first quotient bit is always the integer one.
    assign sig_a    = {1'b1, A[SIG_WIDTH-1:0]};
    assign sig_b    = {1'b1, B[SIG_WIDTH-1:0]};
    assign a_lt_b   = sig_a < sig_b;
    assign exp_init = $signed({2'b00, A[WIDTH-2:SIG_WIDTH]}) - $signed({2'b00, B[WIDTH-2:SIG_WIDTH]})
                      + BIAS_S - (a_lt_b ? EXPC_W'(1) : EXPC_W'(0));

    assign diff     = {1'b0, rem} - {2'b00, divisor};
    assign q_bit    = ~diff[SIG_WIDTH+2];
    assign rem_next = q_bit ? {diff[SIG_WIDTH:0], 1'b0} : {rem[SIG_WIDTH:0], 1'b0};

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = sp_hit ? S_ROUND : S_DIVIDE;
            S_DIVIDE: if (cnt == LAST_CNT) state_next = S_ROUND;
            S_ROUND:  state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= '0;
            else if (state == S_DIVIDE)
                cnt <= cnt + 5'd1;
            if (state == S_ROUND)
                result <= special ? special_val : round_pack(sign, exp, quo, |rem, mode);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sign        <= A[WIDTH-1] ^ B[WIDTH-1];
            mode        <= rnd;
            special     <= sp_hit;
            special_val <= sp_val;
            divisor     <= sig_b;
            rem         <= a_lt_b ? {sig_a, 1'b0} : {1'b0, sig_a};
            exp         <= exp_init;
        end else if (state == S_DIVIDE) begin
            rem <= rem_next;
            quo <= {quo[QBITS-2:0], q_bit};
        end
    end

endmodule
